// File: rtl/modaddsub_pkg.sv
// Shared types and constants for the modular adder/subtractor pipeline.
package modaddsub_pkg;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } buf_state_e;

    // Dual-rail pairs are written as {rail_1, rail_0}.
    localparam logic [1:0] DR_NULL  = 2'b00;
    localparam logic [1:0] DR_TRUE  = 2'b01;
    localparam logic [1:0] DR_FALSE = 2'b10;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic logic [1:0] dr_encode(logic v);
        return v ? DR_TRUE : DR_FALSE;
    endfunction

endpackage

// File: rtl/modaddsub_stage1_pipe_if.sv
// Valid/ready beat interface between the operand source, stage 1 and the carry stages.
interface modaddsub_stage1_pipe_if #(
    parameter int unsigned WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             s;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
    logic             out_s;
    logic [WIDTH:1]   b_0;
    logic [WIDTH:1]   b_1;
    logic [WIDTH-1:0] a_0;
    logic [WIDTH-1:0] a_1;

    modport master (
        output in_valid, s, x, y, out_ready,
        input  in_ready, out_valid, out_s, b_0, b_1, a_0, a_1
    );

    modport slave (
        input  in_valid, s, x, y, out_ready,
        output in_ready, out_valid, out_s, b_0, b_1, a_0, a_1
    );

endinterface

// File: rtl/stage1_bit_cell.sv
// Per-bit encoder: dual-rail propagate and generate terms for one operand bit.
module stage1_bit_cell
    import modaddsub_pkg::*;
(
    input  logic i_s,
    input  logic i_x,
    input  logic i_y,
    output logic o_a_0,
    output logic o_a_1,
    output logic o_b_0,
    output logic o_b_1
);
    logic       w_yc;
    logic [1:0] w_a;
    logic [1:0] w_b;

    assign w_yc  = (i_s == MODE_SUB) ? ~i_y : i_y;
    assign w_a   = dr_encode(i_x ^ w_yc);
    assign w_b   = dr_encode(i_x & w_yc);
    assign o_a_0 = w_a[0];
    assign o_a_1 = w_a[1];
    assign o_b_0 = w_b[0];
    assign o_b_1 = w_b[1];

endmodule

// File: rtl/modaddsub_stage1_pipe.sv
// Stage 1 of the modular adder/subtractor: bit-cell array feeding a two-entry skid buffer.
module modaddsub_stage1_pipe
    import modaddsub_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input logic                          clk,
    input logic                          rst,
    modaddsub_stage1_pipe_if.slave       bus
);
    localparam int unsigned BeatW = 4 * WIDTH + 1;

    logic [WIDTH-1:0] w_a_0;
    logic [WIDTH-1:0] w_a_1;
    logic [WIDTH:1]   w_b_0;
    logic [WIDTH:1]   w_b_1;
    logic [BeatW-1:0] w_beat;
    logic             w_acc;
    logic             w_pop;

    buf_state_e       r_state;
    logic [BeatW-1:0] r_main;
    logic [BeatW-1:0] r_skid;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        stage1_bit_cell u_cell (
            .i_s   (bus.s),
            .i_x   (bus.x[i]),
            .i_y   (bus.y[i]),
            .o_a_0 (w_a_0[i]),
            .o_a_1 (w_a_1[i]),
            .o_b_0 (w_b_0[i+1]),
            .o_b_1 (w_b_1[i+1])
        );
    end

    // Beat layout: {s, b_1, b_0, a_1, a_0}; all-zero is the NULL beat.
    assign w_beat = {bus.s, w_b_1, w_b_0, w_a_1, w_a_0};

    assign bus.in_ready  = (r_state != StTwo) && !rst;
    assign bus.out_valid = (r_state != StEmpty);
    assign w_acc         = bus.in_valid && bus.in_ready;
    assign w_pop         = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StEmpty;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            case (r_state)
                StEmpty: begin
                    if (w_acc) begin
                        r_main  <= w_beat;
                        r_state <= StOne;
                    end
                end
                StOne: begin
                    if (w_acc && !w_pop) begin
                        r_skid  <= w_beat;
                        r_state <= StTwo;
                    end else if (w_acc && w_pop) begin
                        r_main  <= w_beat;
                    end else if (w_pop) begin
                        r_main  <= '0;
                        r_state <= StEmpty;
                    end
                end
                StTwo: begin
                    if (w_pop) begin
                        r_main  <= r_skid;
                        r_skid  <= '0;
                        r_state <= StOne;
                    end
                end
                default: begin
                    r_main  <= '0;
                    r_skid  <= '0;
                    r_state <= StEmpty;
                end
            endcase
        end
    end

    // Main is cleared whenever it is not holding a beat, so idle outputs read NULL.
    assign bus.out_s = r_main[BeatW-1];
    assign bus.b_1   = r_main[4*WIDTH-1 -: WIDTH];
    assign bus.b_0   = r_main[3*WIDTH-1 -: WIDTH];
    assign bus.a_1   = r_main[2*WIDTH-1 -: WIDTH];
    assign bus.a_0   = r_main[WIDTH-1:0];

endmodule

// File: tb/tb_modaddsub_stage1_pipe.sv
// Randomised bench for stage 1: a queue model of the two-entry buffer and arithmetic rail model.
module tb_modaddsub_stage1_pipe;

    typedef struct packed {
        logic        s;
        logic [15:0] x;
        logic [15:0] y;
    } beat_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    beat_t q4[$];
    beat_t q16[$];
    beat_t cur4;
    beat_t cur16;

    logic [64:0] act4;
    logic [64:0] act16;

    modaddsub_stage1_pipe_if #(.WIDTH(4))  if4 ();
    modaddsub_stage1_pipe_if #(.WIDTH(16)) if16 ();

    modaddsub_stage1_pipe #(.WIDTH(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    modaddsub_stage1_pipe #(.WIDTH(16)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16)
    );

    assign act4  = {if4.out_s, 16'(if4.b_1), 16'(if4.b_0), 16'(if4.a_1), 16'(if4.a_0)};
    assign act16 = {if16.out_s, if16.b_1, if16.b_0, if16.a_1, if16.a_0};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // x + yc splits into a carry-free sum (a) and carries (b); subtraction uses one's complement.
    function automatic logic [64:0] exp_out(beat_t bt, int w);
        logic [15:0] m;
        logic [15:0] yc;
        logic [15:0] a;
        logic [15:0] g;
        m  = 16'((32'd1 << w) - 32'd1);
        yc = (bt.s ? ~bt.y : bt.y) & m;
        a  = (bt.x ^ yc) & m;
        g  = bt.x & yc & m;
        return {bt.s, ~g & m, g, ~a & m, a};
    endfunction

    function automatic beat_t rnd_beat(int w);
        beat_t       bt;
        logic [15:0] m;
        m    = 16'((32'd1 << w) - 32'd1);
        bt.s = 1'($urandom_range(0, 1));
        bt.x = 16'($urandom) & m;
        bt.y = 16'($urandom) & m;
        return bt;
    endfunction

    task automatic drv4(logic v, beat_t bt, logic r);
        if4.in_valid  = v;
        if4.s         = bt.s;
        if4.x         = bt.x[3:0];
        if4.y         = bt.y[3:0];
        if4.out_ready = r;
        cur4          = bt;
    endtask

    task automatic drv16(logic v, beat_t bt, logic r);
        if16.in_valid  = v;
        if16.s         = bt.s;
        if16.x         = bt.x;
        if16.y         = bt.y;
        if16.out_ready = r;
        cur16          = bt;
    endtask

    // Advance one clock and update the in-order queue models of both buffers.
    task automatic tick();
        logic a4, a16, p4, p16;
        a4  = if4.in_valid && (q4.size() < 2) && !rst;
        a16 = if16.in_valid && (q16.size() < 2) && !rst;
        p4  = (q4.size() != 0) && if4.out_ready;
        p16 = (q16.size() != 0) && if16.out_ready;
        @(posedge clk);
        if (rst) begin
            q4.delete();
            q16.delete();
        end else begin
            if (p4) void'(q4.pop_front());
            if (a4) q4.push_back(cur4);
            if (p16) void'(q16.pop_front());
            if (a16) q16.push_back(cur16);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (if4.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid4 got=%b exp=0", if4.out_valid); end
        checks++; if (act4 !== 65'd0) begin failures++; $display("FAIL reset_rails4 got=%h exp=0", act4); end
        checks++; if (if4.in_ready !== 1'b0) begin failures++; $display("FAIL reset_rdy4 got=%b exp=0", if4.in_ready); end
        checks++; if (act16 !== 65'd0 || if16.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out16 got=%h/%b exp=0/0", act16, if16.out_valid); end
        rst = 1'b0;
        #1;
        checks++; if (if4.in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_rdy4 got=%b exp=1", if4.in_ready); end
        checks++; if (if16.in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_rdy16 got=%b exp=1", if16.in_ready); end
    endtask

    task automatic test_add();
        drv4(1'b1, beat_t'{1'b0, 16'h5, 16'h3}, 1'b1);
        #1;
        checks++; if (if4.in_ready !== 1'b1) begin failures++; $display("FAIL add_rdy got=%b exp=1", if4.in_ready); end
        tick();
        drv4(1'b0, '0, 1'b1);
        #1;
        checks++; if (if4.out_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", if4.out_valid); end
        checks++; if (act4 !== {1'b0, 16'hE, 16'h1, 16'h9, 16'h6}) begin failures++; $display("FAIL add_rails got=%h exp=%h", act4, {1'b0, 16'hE, 16'h1, 16'h9, 16'h6}); end
    endtask

    task automatic test_sub();
        // Offered while the add result is being popped: replaces main with no bubble.
        drv4(1'b1, beat_t'{1'b1, 16'h5, 16'h3}, 1'b1);
        tick();
        drv4(1'b0, '0, 1'b1);
        #1;
        checks++; if (if4.out_valid !== 1'b1) begin failures++; $display("FAIL sub_valid got=%b exp=1", if4.out_valid); end
        checks++; if (act4 !== {1'b1, 16'hB, 16'h4, 16'h6, 16'h9}) begin failures++; $display("FAIL sub_rails got=%h exp=%h", act4, {1'b1, 16'hB, 16'h4, 16'h6, 16'h9}); end
        tick();
        checks++; if (if4.out_valid !== 1'b0 || act4 !== 65'd0) begin failures++; $display("FAIL sub_drain got=%b/%h exp=0/0", if4.out_valid, act4); end
    endtask

    task automatic test_backpressure();
        beat_t       bl[3];
        logic [64:0] got[$];
        logic        took;
        for (int k = 0; k < 3; k++) bl[k] = rnd_beat(4);
        drv4(1'b1, bl[0], 1'b0);
        #1;
        checks++; if (if4.in_ready !== 1'b1) begin failures++; $display("FAIL bp_rdy_a got=%b exp=1", if4.in_ready); end
        tick();
        drv4(1'b1, bl[1], 1'b0);
        #1;
        checks++; if (if4.in_ready !== 1'b1) begin failures++; $display("FAIL bp_rdy_b got=%b exp=1", if4.in_ready); end
        tick();
        drv4(1'b1, bl[2], 1'b0);
        #1;
        checks++; if (if4.in_ready !== 1'b0) begin failures++; $display("FAIL bp_rdy_c got=%b exp=0", if4.in_ready); end
        tick();
        checks++; if (act4 !== exp_out(bl[0], 4) || if4.out_valid !== 1'b1) begin failures++; $display("FAIL bp_stable got=%h exp=%h", act4, exp_out(bl[0], 4)); end
        if4.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (if4.out_valid === 1'b1) got.push_back(act4);
            took = if4.in_valid && if4.in_ready;
            tick();
            if (took) drv4(1'b0, '0, 1'b1);
        end
        checks++; if (got.size() != 3) begin failures++; $display("FAIL bp_count got=%0d exp=3", got.size()); end
        for (int k = 0; k < 3; k++) begin
            if (k < got.size()) begin
                checks++; if (got[k] !== exp_out(bl[k], 4)) begin failures++; $display("FAIL bp_order%0d got=%h exp=%h", k, got[k], exp_out(bl[k], 4)); end
            end
        end
    endtask

    task automatic test_streaming();
        beat_t bs[16];
        for (int i = 0; i < 16; i++) bs[i] = rnd_beat(4);
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) drv4(1'b1, bs[i], 1'b1);
            else drv4(1'b0, '0, 1'b1);
            #1;
            checks++; if (if4.in_ready !== 1'b1) begin failures++; $display("FAIL stream_rdy%0d got=%b exp=1", i, if4.in_ready); end
            checks++; if (if4.out_valid !== (i > 0)) begin failures++; $display("FAIL stream_valid%0d got=%b exp=%b", i, if4.out_valid, i > 0); end
            if (i > 0) begin
                checks++; if (act4 !== exp_out(bs[i-1], 4)) begin failures++; $display("FAIL stream_beat%0d got=%h exp=%h", i - 1, act4, exp_out(bs[i-1], 4)); end
            end
            tick();
        end
        checks++; if (if4.out_valid !== 1'b0) begin failures++; $display("FAIL stream_end got=%b exp=0", if4.out_valid); end
    endtask

    task automatic test_reset_in_two();
        drv4(1'b1, rnd_beat(4), 1'b0);
        tick();
        drv4(1'b1, rnd_beat(4), 1'b0);
        tick();
        rst = 1'b1;
        drv4(1'b1, rnd_beat(4), 1'b0);
        #1;
        checks++; if (if4.in_ready !== 1'b0) begin failures++; $display("FAIL rst2_rdy_during got=%b exp=0", if4.in_ready); end
        tick();
        checks++; if (if4.out_valid !== 1'b0 || act4 !== 65'd0) begin failures++; $display("FAIL rst2_flush got=%b/%h exp=0/0", if4.out_valid, act4); end
        rst = 1'b0;
        drv4(1'b0, '0, 1'b1);
        #1;
        checks++; if (if4.in_ready !== 1'b1) begin failures++; $display("FAIL rst2_rdy_after got=%b exp=1", if4.in_ready); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (if4.out_valid !== 1'b0) begin failures++; $display("FAIL rst2_ghost%0d got=%b exp=0", i, if4.out_valid); end
        end
    endtask

    task automatic test_sweep16();
        for (int i = 0; i < 400; i++) begin
            drv16(1'($urandom_range(0, 1)), rnd_beat(16), ($urandom_range(0, 3) != 0));
            #1;
            checks++; if (if16.in_ready !== (q16.size() < 2)) begin failures++; $display("FAIL sweep_rdy%0d got=%b exp=%b", i, if16.in_ready, q16.size() < 2); end
            if (q16.size() != 0) begin
                checks++; if (if16.out_valid !== 1'b1 || act16 !== exp_out(q16[0], 16)) begin failures++; $display("FAIL sweep_beat%0d got=%b/%h exp=1/%h", i, if16.out_valid, act16, exp_out(q16[0], 16)); end
                checks++; if ((if16.a_0 ^ if16.a_1) !== 16'hFFFF || (if16.b_0 ^ if16.b_1) !== 16'hFFFF) begin failures++; $display("FAIL sweep_dual%0d got=%h exp=complementary", i, act16); end
            end else begin
                checks++; if (if16.out_valid !== 1'b0 || act16 !== 65'd0) begin failures++; $display("FAIL sweep_null%0d got=%b/%h exp=0/0", i, if16.out_valid, act16); end
            end
            tick();
        end
        drv16(1'b0, '0, 1'b1);
        tick();
        tick();
        tick();
        checks++; if (if16.out_valid !== 1'b0 || act16 !== 65'd0) begin failures++; $display("FAIL sweep_drain got=%b/%h exp=0/0", if16.out_valid, act16); end
    endtask

    initial begin
        rst = 1'b1;
        drv4(1'b0, '0, 1'b0);
        drv16(1'b0, '0, 1'b0);
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_streaming();
        test_reset_in_two();
        test_sweep16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/modaddsub_stage1_pipe.md
# modaddsub_stage1_pipe

Parametrised, pipelined first stage of the modular adder/subtractor. For each bit position it forms the operand-conditioned propagate (a) and generate (b) terms in dual-rail form, with y inverted when subtracting. Results sit in a registered two-entry valid/ready buffer that feeds the prefix/carry stages downstream. It generalises the fixed 4-bit combinational first stage to any width and adds flow control, NULL spacers and a forwarded mode bit.

## Interface
- WIDTH, 4, operand width in bits (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat present
- in_ready  out  1  block can accept a beat
- s  in  1  mode: 0 = add, 1 = subtract
- x  in  WIDTH  operand x
- y  in  WIDTH  operand y
- out_valid  out  1  output beat present
- out_ready  in  1  downstream accepts beat
- out_s  out  1  mode of the output beat; used downstream as carry-in
- b_0, b_1  out  WIDTH, indexed [WIDTH:1]  generate rails; b_0 = true rail, b_1 = complement rail
- a_0, a_1  out  WIDTH, indexed [WIDTH-1:0]  propagate rails; a_0 = true, a_1 = complement

## Operation
- Per bit i: yc_i = y_i ^ s; a_i = x_i ^ yc_i; b_{i+1} = x_i & yc_i.
- Subtraction is one's complement here. The +1 is supplied downstream through out_s as carry-in.
- Dual-rail encoding:
  - Valid beat: each rail pair is complementary (x_0 = v, x_1 = ~v).
  - No valid beat: every pair is NULL (both rails 0).
  - The pattern 11 is never driven.
- Buffer states:
  - EMPTY: no beat held.
  - ONE: main register holds a beat.
  - TWO: main register and skid register both hold a beat.
- Signal definitions:
  - in_ready = (state != TWO) && !rst.
  - out_valid = (state != EMPTY).
  - Outputs always come from the main register.
- Transitions (acc = in_valid && in_ready; pop = out_valid && out_ready):
  - EMPTY: acc → ONE, new beat loads main.
  - ONE:
    - acc && !pop → TWO, new beat loads skid.
    - acc && pop → ONE, new beat loads main.
    - !acc && pop → EMPTY.
    - otherwise hold.
  - TWO: pop → ONE, skid moves to main. acc is impossible in TWO.
- Main and skid each store the encoded rails plus s. Encoding happens before the register.
- Beats leave in strict arrival order. No beat is dropped or duplicated.

## Timing
- Latency is 1 cycle: a beat accepted at edge k is visible on the outputs after edge k.
- Throughput is 1 beat/cycle while out_ready is held high.
- While rst is high, at the next edge:
  - state → EMPTY.
  - out_valid = 0, out_s = 0, all rails = NULL.
  - in_ready is forced low during rst and is 1 in the first cycle after rst deasserts.
- Reset mid-operation discards both buffered beats. A beat offered in the reset cycle is not accepted.
- Output stability: while out_valid && !out_ready, all outputs hold constant.
- Simultaneous acc and pop in ONE: no bubble; main is replaced in the same edge.
- in_ready depends only on registered state and rst. There is no combinational path from out_ready to in_ready.

## Structure
- Package modaddsub_pkg:
  - buffer state enum (EMPTY/ONE/TWO).
  - dual-rail constants: NULL = 2'b00, TRUE = 2'b01 as {_1,_0}, FALSE = 2'b10.
  - MODE_ADD / MODE_SUB.
- Sub-module stage1_bit_cell: combinational per-bit encoder.
  - Inputs: s, x_i, y_i.
  - Outputs: a_0/a_1 and b_0/b_1 for that bit.
  - Instantiated WIDTH times in a generate loop.
- Top level: the bit-cell array, main and skid registers, and the state machine.

## Test plan
- Add, WIDTH=4: s=0, x=0101, y=0011, out_ready=1.
  - Next cycle: a_0=0110, a_1=1001, b_0[4:1]=0001, b_1=1110, out_s=0.
- Subtract: s=1, x=0101, y=0011.
  - a_0=1001, b_0[4:1]=0100, b_1=1011, out_s=1.
- Backpressure: out_ready=0, offer beats A, B, C on consecutive cycles.
  - A and B accepted; in_ready=0 when C is offered.
  - Raise out_ready: outputs A, B, C in order, no duplicates.
- Streaming: out_ready=1, 16 back-to-back random beats.
  - out_valid high 16 consecutive cycles after the first.
  - Each beat matches the reference model.
- Reset in TWO: assert rst for 1 cycle.
  - out_valid=0, all rails 00, in_ready=0 during rst, 1 on the following cycle.
  - The beat offered during rst never appears.
- WIDTH=16 sweep, random s, x, y with random stalls.
  - Every valid output pair is complementary; every idle output is NULL.
